// File: rtl/apb_req_arbiter.sv
// Round-robin scheduler sharing one APB master among NUM_REQ requesters.
// One transfer outstanding at a time; response is returned to the granted requester.
module apb_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int HANG_LIMIT = 64
) (
   input  logic                          pclk,
   input  logic                          presetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_slverr,
   output logic                          transfer,
   output logic                          rd_wr,
   output logic [ADDR_WIDTH-1:0]         write_addr,
   output logic [ADDR_WIDTH-1:0]         read_addr,
   output logic [DATA_WIDTH-1:0]         write_data,
   input  logic                          pselx,
   input  logic                          penable,
   input  logic                          pready,
   input  logic                          pslverr,
   input  logic [DATA_WIDTH-1:0]         read_data,
   output logic                          busy,
   output logic                          hang
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(HANG_LIMIT + 1);

   localparam logic [1:0] ARB   = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;

   logic [1:0]    state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] sel_idx;
   logic [PW-1:0] cand;
   logic [PW-1:0] nxt_ptr;
   logic          sel_found;
   logic [CW-1:0] wait_cnt;
   logic          err;
   logic          cmpl;
   cmd_t          cmd_q;

   assign addr_v  = req_addr;
   assign wdata_v = req_wdata;

   assign cmpl       = pselx & penable & (pready | pslverr);
   assign busy       = (state != ARB);
   assign rd_wr      = cmd_q.wr;
   assign write_addr = cmd_q.addr;
   assign read_addr  = cmd_q.addr;
   assign write_data = cmd_q.wdata;
   assign nxt_ptr    = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      if (presetn && (state == ARB) && sel_found)
         req_ready[sel_idx] = 1'b1;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state      <= ARB;
         rr_ptr     <= '0;
         gnt_idx    <= '0;
         wait_cnt   <= '0;
         err        <= 1'b0;
         hang       <= 1'b0;
         transfer   <= 1'b0;
         cmd_q      <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else begin
         transfer  <= 1'b0;
         rsp_valid <= '0;
         case (state)
            ARB: if (sel_found) begin
               gnt_idx     <= sel_idx;
               rr_ptr      <= nxt_ptr;
               cmd_q.wr    <= req_write[sel_idx];
               cmd_q.addr  <= addr_v[sel_idx];
               cmd_q.wdata <= wdata_v[sel_idx];
               transfer    <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (cmpl) begin
                  err   <= pslverr;
                  state <= DONE;
               end else if (wait_cnt != CW'(HANG_LIMIT)) begin
                  wait_cnt <= wait_cnt + CW'(1);
                  // Sticky: the FSM keeps waiting, only reset clears it.
                  if (wait_cnt == CW'(HANG_LIMIT - 1))
                     hang <= 1'b1;
               end
            end
            DONE: begin
               rsp_valid[gnt_idx] <= 1'b1;
               rsp_rdata          <= cmd_q.wr ? '0 : read_data;
               rsp_slverr         <= err;
               state              <= ARB;
            end
            default: state <= ARB;
         endcase
      end
   end
endmodule
